// File: rtl/sram_req_arbiter.sv
// Two-master sram-like request arbiter with an in-order owner FIFO for responses.
// Define ARB_RR_EN for round-robin tie breaking; default is fixed priority m1 > m0.
module sram_req_arbiter #(
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);
    localparam int OST = 1 << PTR_W;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state;
    logic             gnt_vld;
    logic             sel;
    logic             last_sel;
    logic             tie_win;
    logic             hs;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             head;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [OST-1:0]   owner;

`ifdef ARB_RR_EN
    logic rr_last;
    assign tie_win = ~rr_last;
`else
    assign tie_win = 1'b1;
`endif

    // sel falls back to the last granted master so s_* stays stable when idle
    always_comb begin
        gnt_vld = 1'b0;
        sel     = last_sel;
        case (state)
            IDLE: begin
                gnt_vld = m0_req | m1_req;
                if (m0_req & m1_req) sel = tie_win;
                else if (m1_req)     sel = 1'b1;
                else if (m0_req)     sel = 1'b0;
            end
            LOCK0: begin
                gnt_vld = 1'b1;
                sel     = 1'b0;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                sel     = 1'b1;
            end
            default: begin
                gnt_vld = 1'b0;
                sel     = last_sel;
            end
        endcase
    end

    assign s_req   = gnt_vld & (sel ? m1_req : m0_req) & ~full & resetn;
    assign s_wr    = sel ? m1_wr    : m0_wr;
    assign s_size  = sel ? m1_size  : m0_size;
    assign s_wstrb = sel ? m1_wstrb : m0_wstrb;
    assign s_addr  = sel ? m1_addr  : m0_addr;
    assign s_wdata = sel ? m1_wdata : m0_wdata;

    assign hs         = s_req & s_addr_ok;
    assign m0_addr_ok = hs & ~sel;
    assign m1_addr_ok = hs & sel;

    assign empty     = (count == '0);
    assign push      = hs;
    assign pop       = s_data_ok & ~empty;
    assign head      = owner[rptr];
    assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    assign m0_data_ok = pop & ~head;
    assign m1_data_ok = pop & head;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            last_sel <= 1'b0;
            count    <= '0;
            full     <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            owner    <= '0;
        end else begin
            case (state)
                IDLE:    if (gnt_vld & ~hs) state <= sel ? LOCK1 : LOCK0;
                LOCK0:   if (hs) state <= IDLE;
                LOCK1:   if (hs) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (gnt_vld) last_sel <= sel;
            if (push) begin
                owner[wptr] <= sel;
                wptr        <= wptr + PTR_W'(1);
            end
            if (pop) rptr <= rptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == (PTR_W+1)'(OST));
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  rr_last <= 1'b0;
        else if (hs)  rr_last <= sel;
    end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Table-driven directed bench for sram_req_arbiter: one vector per clock cycle,
// inputs driven on the falling edge and outputs compared before the next rising edge.
module tb_sram_req_arbiter;
    localparam logic [31:0] A0 = 32'h1fc0_0000;
    localparam logic [31:0] A1 = 32'h8000_1000;
    localparam logic [31:0] RD = 32'h3c1d_0000;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m1_req;
    logic        m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic        rstn, r0, r1, aok, dok;
        logic [31:0] rd;
        logic        ereq, esel, ea0, ea1, ed0, ed1;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    sram_req_arbiter #(.PTR_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(1'b0), .m0_size(2'd2), .m0_wstrb(4'hf),
        .m0_addr(A0), .m0_wdata(32'h0),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(1'b1), .m1_size(2'd1), .m1_wstrb(4'h3),
        .m1_addr(A1), .m1_wdata(32'hdead_beef),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    function automatic void add(
        input logic rstn, r0, r1, aok, dok, input logic [31:0] rd,
        input logic ereq, esel, ea0, ea1, ed0, ed1);
        vec_t v;
        v.rstn = rstn; v.r0 = r0; v.r1 = r1; v.aok = aok; v.dok = dok; v.rd = rd;
        v.ereq = ereq; v.esel = esel; v.ea0 = ea0; v.ea1 = ea1;
        v.ed0 = ed0; v.ed1 = ed1;
        tv.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [107:0] act, exp;
        @(negedge clk);
        resetn    = v.rstn;
        m0_req    = v.r0;
        m1_req    = v.r1;
        s_addr_ok = v.aok;
        s_data_ok = v.dok;
        s_rdata   = v.rd;
        #2;
        act = {s_req, s_addr, s_wr, s_size, s_wstrb,
               m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, m0_rdata, m1_rdata};
        exp = {v.ereq, v.esel ? A1 : A0, v.esel, v.esel ? 2'd1 : 2'd2,
               v.esel ? 4'h3 : 4'hf,
               v.ea0, v.ea1, v.ed0, v.ed1, v.rd, v.rd};
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL vec%0d: got %h want %h", idx, act, exp);
        end
    endtask

    initial begin
        logic o;
        resetn = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

        // reset: request masked, idle defaults
        add(0, 1,0, 0,0, 32'h0,  0,0, 0,0, 0,0);
        add(1, 0,0, 0,0, 32'h0,  0,0, 0,0, 0,0);
        // single read from m0
        add(1, 1,0, 1,0, 32'h0,  1,0, 1,0, 0,0);
        add(1, 0,0, 0,1, RD,     0,0, 0,0, 1,0);
        // tie for four accepts, then in-order returns
        for (int i = 0; i < 4; i++) begin
            o = RR ? ~i[0] : 1'b1;
            add(1, 1,1, 1,0, 32'h0,  1,o, ~o,o, 0,0);
        end
        for (int i = 0; i < 4; i++) begin
            o = RR ? ~i[0] : 1'b1;
            add(1, 0,0, 0,1, 32'h100 + i,  0,~RR, 0,0, ~o,o);
        end
        // lock: m0 held while addr_ok low, m1 must wait
        add(1, 1,0, 0,0, 32'h0,  1,0, 0,0, 0,0);
        add(1, 1,1, 0,0, 32'h0,  1,0, 0,0, 0,0);
        add(1, 1,1, 0,0, 32'h0,  1,0, 0,0, 0,0);
        add(1, 1,1, 1,0, 32'h0,  1,0, 1,0, 0,0);
        add(1, 0,1, 1,0, 32'h0,  1,1, 0,1, 0,0);
        add(1, 0,0, 0,1, 32'h11, 0,1, 0,0, 1,0);
        add(1, 0,0, 0,1, 32'h22, 0,1, 0,0, 0,1);
        // full: four accepts, request blocked, pop frees next cycle
        for (int i = 0; i < 4; i++)
            add(1, 0,1, 1,0, 32'h0,  1,1, 0,1, 0,0);
        add(1, 0,1, 1,0, 32'h0,  0,1, 0,0, 0,0);
        add(1, 0,1, 0,1, 32'h33, 0,1, 0,0, 0,1);
        add(1, 0,1, 1,0, 32'h0,  1,1, 0,1, 0,0);
        for (int i = 0; i < 4; i++)
            add(1, 0,0, 0,1, 32'h40 + i,  0,1, 0,0, 0,1);
        // wrap and mix: push and pop in the same cycle
        add(1, 1,0, 1,0, 32'h0,  1,0, 1,0, 0,0);
        for (int k = 1; k < 10; k++) begin
            o = k[0];
            add(1, ~o,o, 1,1, 32'h50 + k,  1,o, ~o,o, o,~o);
        end
        add(1, 0,0, 0,1, 32'h5a, 0,1, 0,0, 0,1);
        // spurious data_ok while empty
        add(1, 0,0, 0,1, 32'h77, 0,1, 0,0, 0,0);
        // reset with three outstanding
        for (int i = 0; i < 3; i++)
            add(1, 1,0, 1,0, 32'h0,  1,0, 1,0, 0,0);
        add(0, 1,0, 1,1, 32'h88, 0,0, 0,0, 0,0);
        add(1, 0,0, 0,1, 32'h99, 0,0, 0,0, 0,0);
        add(1, 0,1, 0,0, 32'h0,  1,1, 0,0, 0,0);
        add(1, 0,1, 1,0, 32'h0,  1,1, 0,1, 0,0);
        add(1, 0,0, 0,1, 32'haa, 0,1, 0,0, 0,1);
        add(1, 0,0, 0,0, 32'h0,  0,1, 0,0, 0,0);

        for (int i = 0; i < tv.size(); i++)
            apply(tv[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
